// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle CPU controller: opcodes, FSM state
// encodings, ALU operation codes and small opcode-class helpers.
package mcpu_pkg;

  // Instruction opcodes (bits [31:26] of the instruction register)
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // FSM states; the encoding is visible on the debug state port
  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_ALU = 3'b010,
    S_EXE_BR  = 3'b011,
    S_EXE_LS  = 3'b100,
    S_MEM     = 3'b101,
    S_WB_ALU  = 3'b110,
    S_WB_LD   = 3'b111
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Next-PC source select
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP = 2'b11;

  // Destination register select
  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  // True for the three unconditional jumps, which retire in ID
  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  endfunction

  // True for the two conditional branches
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decode for datapath steering fields. Carries no
// state; the FSM in multi_cycle_ctrl gates everything that writes state.
module ctrl_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic [1:0] reg_dst,
  output logic       alu_wr
);

  // Opcode -> ALU op, operand selects, extension mode and destination select
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    reg_dst   = REGDST_RD;
    alu_wr    = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_wr = 1'b1;
      end
      OP_SUB: begin
        alu_op = ALU_SUB;
        alu_wr = 1'b1;
      end
      OP_ADDI: begin
        alu_src_b = 1'b1;
        reg_dst   = REGDST_RT;
        alu_wr    = 1'b1;
      end
      OP_OR: begin
        alu_op = ALU_OR;
        alu_wr = 1'b1;
      end
      OP_AND: begin
        alu_op = ALU_AND;
        alu_wr = 1'b1;
      end
      OP_ORI: begin
        alu_op    = ALU_OR;
        alu_src_b = 1'b1;
        ext_sel   = 1'b0;
        reg_dst   = REGDST_RT;
        alu_wr    = 1'b1;
      end
      OP_SLL: begin
        alu_op    = ALU_SLL;
        alu_src_a = 1'b1;
        alu_wr    = 1'b1;
      end
      OP_SLT: begin
        alu_op = ALU_SLT;
        alu_wr = 1'b1;
      end
      OP_SW, OP_LW: begin
        alu_src_b = 1'b1;
        reg_dst   = REGDST_RT;
      end
      OP_BEQ, OP_BNE: begin
        alu_op  = ALU_SUB;
        reg_dst = REGDST_RT;
      end
      OP_JAL: begin
        reg_dst = REGDST_RA;
      end
      default: begin
        // j, jr, halt and undefined opcodes: no register result, add op
        alu_op  = ALU_ADD;
        reg_dst = REGDST_RD;
        alu_wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: instruction FSM plus state-gated write
// enables. Outputs are combinational decodes of (state, opcode, zero).
module multi_cycle_ctrl
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       WrRegDSrc,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  state_t state_r;
  state_t next_state_s;

  logic pc_wre_s;
  logic ir_wre_s;
  logic ins_mem_rw_s;
  logic m_rd_s;
  logic m_wr_s;
  logic reg_wre_s;
  logic wr_reg_d_src_s;
  logic branch_taken_s;
  logic alu_wr_s;
  logic [1:0] pc_src_s;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .alu_op    (ALUOp),
    .alu_src_a (ALUSrcA),
    .alu_src_b (ALUSrcB),
    .ext_sel   (ExtSel),
    .reg_dst   (RegDst),
    .alu_wr    (alu_wr_s)
  );

  // State register; reset returns to IF from any state, including halt
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: instruction class selects the path through the FSM
  always_comb begin
    next_state_s = S_IF;
    case (state_r)
      S_IF: next_state_s = S_ID;
      S_ID: begin
        if (is_jump(opcode)) begin
          next_state_s = S_IF;
        end else if (is_branch(opcode)) begin
          next_state_s = S_EXE_BR;
        end else if ((opcode == OP_SW) || (opcode == OP_LW)) begin
          next_state_s = S_EXE_LS;
        end else if (opcode == OP_HALT) begin
          next_state_s = S_ID;
        end else begin
          next_state_s = S_EXE_ALU;
        end
      end
      S_EXE_ALU: next_state_s = S_WB_ALU;
      S_EXE_BR:  next_state_s = S_IF;
      S_EXE_LS:  next_state_s = S_MEM;
      S_MEM: begin
        if (opcode == OP_LW) begin
          next_state_s = S_WB_LD;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_WB_ALU: next_state_s = S_IF;
      S_WB_LD:  next_state_s = S_IF;
      default:  next_state_s = S_IF;
    endcase
  end

  // Output decode: PC is written only in the last cycle of each instruction
  always_comb begin
    pc_wre_s       = 1'b0;
    ir_wre_s       = 1'b0;
    ins_mem_rw_s   = 1'b0;
    m_rd_s         = 1'b0;
    m_wr_s         = 1'b0;
    reg_wre_s      = 1'b0;
    wr_reg_d_src_s = 1'b0;
    branch_taken_s = 1'b0;
    case (state_r)
      S_IF: begin
        ir_wre_s     = 1'b1;
        ins_mem_rw_s = 1'b1;
      end
      S_ID: begin
        pc_wre_s  = is_jump(opcode);
        reg_wre_s = (opcode == OP_JAL);
      end
      S_EXE_BR: begin
        pc_wre_s       = 1'b1;
        branch_taken_s = ((opcode == OP_BEQ) && zero) ||
                         ((opcode == OP_BNE) && !zero);
      end
      S_MEM: begin
        m_rd_s   = (opcode == OP_LW);
        m_wr_s   = (opcode == OP_SW);
        // anything that does not continue to WB_LD retires here
        pc_wre_s = (opcode != OP_LW);
      end
      S_WB_ALU: begin
        pc_wre_s  = 1'b1;
        // undefined opcodes pass through as a NOP without a register write
        reg_wre_s = alu_wr_s;
      end
      S_WB_LD: begin
        pc_wre_s       = 1'b1;
        reg_wre_s      = 1'b1;
        wr_reg_d_src_s = 1'b1;
      end
      default: begin
        pc_wre_s = 1'b0;
      end
    endcase
  end

  // Next-PC source select
  always_comb begin
    pc_src_s = PCSRC_SEQ;
    if (opcode == OP_JR) begin
      pc_src_s = PCSRC_JR;
    end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
      pc_src_s = PCSRC_JUMP;
    end else if (branch_taken_s) begin
      pc_src_s = PCSRC_BR;
    end else begin
      pc_src_s = PCSRC_SEQ;
    end
  end

  // State-changing enables are suppressed combinationally while reset is high
  assign PCWre     = pc_wre_s  & ~reset;
  assign IRWre     = ir_wre_s  & ~reset;
  assign RegWre    = reg_wre_s & ~reset;
  assign mRD       = m_rd_s    & ~reset;
  assign mWR       = m_wr_s    & ~reset;
  assign InsMemRW  = ins_mem_rw_s;
  assign WrRegDSrc = wr_reg_d_src_s;
  assign PCSrc     = pc_src_s;
  assign state     = state_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed vector table, halt and
// reset sequences, then random instruction streams against a path model.
module tb_multi_cycle_ctrl;
  import mcpu_pkg::*;

  localparam logic [2:0] T_IF  = 3'd0;
  localparam logic [2:0] T_ID  = 3'd1;
  localparam logic [2:0] T_ALU = 3'd2;
  localparam logic [2:0] T_BR  = 3'd3;
  localparam logic [2:0] T_LS  = 3'd4;
  localparam logic [2:0] T_MEM = 3'd5;
  localparam logic [2:0] T_WBA = 3'd6;
  localparam logic [2:0] T_WBL = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic [2:0] st;
    logic       pcw, irw, rgw, mrd, mwr, wds;
    logic [1:0] pcsrc, regdst;
    logic [2:0] aluop;
  } vec_t;

  vec_t tbl[$];
  int   path_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic rst, input logic [5:0] op, input logic z,
                         input logic [2:0] st, input logic pcw, input logic irw,
                         input logic rgw, input logic mrd, input logic mwr,
                         input logic wds, input logic [1:0] pcsrc,
                         input logic [1:0] regdst, input logic [2:0] aluop);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.st = st;
    v.pcw = pcw; v.irw = irw; v.rgw = rgw; v.mrd = mrd; v.mwr = mwr; v.wds = wds;
    v.pcsrc = pcsrc; v.regdst = regdst; v.aluop = aluop;
    tbl.push_back(v);
  endtask

  function automatic logic is_rtype(input logic [5:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_OR || op == OP_AND ||
           op == OP_SLL || op == OP_SLT;
  endfunction

  function automatic logic is_itype(input logic [5:0] op);
    return op == OP_ADDI || op == OP_ORI || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_BNE;
  endfunction

  // Expected ALU code per instruction; care=0 where the op has no ALU role
  task automatic exp_alu(input logic [5:0] op, output logic [2:0] code, output logic care);
    care = 1'b1;
    code = 3'd0;
    if (op == OP_ADD || op == OP_ADDI || op == OP_LW || op == OP_SW) code = 3'd0;
    else if (op == OP_SUB || op == OP_BEQ || op == OP_BNE) code = 3'd1;
    else if (op == OP_SLL) code = 3'd2;
    else if (op == OP_OR || op == OP_ORI) code = 3'd3;
    else if (op == OP_AND) code = 3'd4;
    else if (op == OP_SLT) code = 3'd5;
    else care = 1'b0;
  endtask

  // Sequence of states an instruction walks through, starting at IF
  task automatic build_path(input logic [5:0] op);
    path_q = {};
    path_q.push_back(int'(T_IF));
    path_q.push_back(int'(T_ID));
    if (op == OP_J || op == OP_JR || op == OP_JAL) begin
    end else if (op == OP_BEQ || op == OP_BNE) begin
      path_q.push_back(int'(T_BR));
    end else if (op == OP_LW) begin
      path_q.push_back(int'(T_LS)); path_q.push_back(int'(T_MEM)); path_q.push_back(int'(T_WBL));
    end else if (op == OP_SW) begin
      path_q.push_back(int'(T_LS)); path_q.push_back(int'(T_MEM));
    end else begin
      path_q.push_back(int'(T_ALU)); path_q.push_back(int'(T_WBA));
    end
  endtask

  logic [5:0] defined_ops [15];

  initial begin
    logic [15:0] act_w, exp_w;
    defined_ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
                    OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL};

    //       rst op       z  state  pcw irw rgw mrd mwr wds pcsrc  regdst alu
    add_vec(1'b1, OP_ADD, 1'b0, T_IF,  0,0,0,0,0,0, 2'b00, 2'b10, 3'd0);
    add_vec(1'b0, OP_ADD, 1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b10, 3'd0);
    add_vec(1'b0, OP_ADD, 1'b0, T_ID,  0,0,0,0,0,0, 2'b00, 2'b10, 3'd0);
    add_vec(1'b0, OP_ADD, 1'b0, T_ALU, 0,0,0,0,0,0, 2'b00, 2'b10, 3'd0);
    add_vec(1'b0, OP_ADD, 1'b0, T_WBA, 1,0,1,0,0,0, 2'b00, 2'b10, 3'd0);
    add_vec(1'b0, OP_LW,  1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_LW,  1'b0, T_ID,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_LW,  1'b0, T_LS,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_LW,  1'b0, T_MEM, 0,0,0,1,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_LW,  1'b0, T_WBL, 1,0,1,0,0,1, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_BEQ, 1'b1, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BEQ, 1'b1, T_ID,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BEQ, 1'b1, T_BR,  1,0,0,0,0,0, 2'b01, 2'b01, 3'd1);
    add_vec(1'b0, OP_BEQ, 1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BEQ, 1'b0, T_ID,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BEQ, 1'b0, T_BR,  1,0,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BNE, 1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BNE, 1'b0, T_ID,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd1);
    add_vec(1'b0, OP_BNE, 1'b0, T_BR,  1,0,0,0,0,0, 2'b01, 2'b01, 3'd1);
    add_vec(1'b0, OP_JAL, 1'b0, T_IF,  0,1,0,0,0,0, 2'b11, 2'b00, 3'd0);
    add_vec(1'b0, OP_JAL, 1'b0, T_ID,  1,0,1,0,0,0, 2'b11, 2'b00, 3'd0);
    add_vec(1'b0, OP_SW,  1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_SW,  1'b0, T_ID,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_SW,  1'b0, T_LS,  0,0,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b1, OP_SW,  1'b0, T_MEM, 0,0,0,0,0,0, 2'b00, 2'b01, 3'd0);
    add_vec(1'b0, OP_SW,  1'b0, T_IF,  0,1,0,0,0,0, 2'b00, 2'b01, 3'd0);

    // First reset edge, then the table starts with the second reset cycle
    reset = 1'b1; opcode = OP_ADD; zero = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; opcode = tbl[i].op; zero = tbl[i].z;
      #1;
      act_w = {state, PCWre, IRWre, RegWre, mRD, mWR, WrRegDSrc, PCSrc, RegDst, ALUOp};
      exp_w = {tbl[i].st, tbl[i].pcw, tbl[i].irw, tbl[i].rgw, tbl[i].mrd, tbl[i].mwr,
               tbl[i].wds, tbl[i].pcsrc, tbl[i].regdst, tbl[i].aluop};
      check($sformatf("vec%0d {st,pcw,irw,rgw,mrd,mwr,wds,pcsrc,rdst,aluop}", i),
            32'(act_w), 32'(exp_w));
      @(posedge clk); #1;
    end

    // Halt decoded in ID: stays there with the PC frozen
    for (int c = 0; c < 20; c++) begin
      opcode = OP_HALT;
      #1;
      check($sformatf("halt_state_c%0d", c), 32'(state), 32'(T_ID));
      check($sformatf("halt_pcwre_c%0d", c), 32'(PCWre), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("halt_reset_pcwre", 32'(PCWre), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("halt_reset_state", 32'(state), 32'(T_IF));
    check("halt_reset_irwre", 32'(IRWre), 32'd1);

    // Random instruction stream against the path model
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic       z, care, taken, last, writes;
      logic [2:0] alu_code;
      logic [1:0] e_pcsrc;
      logic [10:0] e_ctl, a_ctl;
      int         st;
      if ($urandom_range(0, 4) == 0) op = {3'b001, 3'($urandom_range(0, 7))};
      else op = defined_ops[$urandom_range(0, 14)];
      z = 1'($urandom_range(0, 1));
      build_path(op);
      exp_alu(op, alu_code, care);
      taken  = (op == OP_BEQ && z) || (op == OP_BNE && !z);
      writes = is_rtype(op) || op == OP_ADDI || op == OP_ORI || op == OP_LW || op == OP_JAL;
      for (int k = 0; k < path_q.size(); k++) begin
        opcode = op; zero = z;
        #1;
        st   = path_q[k];
        last = (k == path_q.size() - 1);
        if (op == OP_JR) e_pcsrc = 2'b10;
        else if (op == OP_J || op == OP_JAL) e_pcsrc = 2'b11;
        else if (st == int'(T_BR) && taken) e_pcsrc = 2'b01;
        else e_pcsrc = 2'b00;
        e_ctl = {last, (k == 0), (k == 0), last && writes,
                 (op == OP_LW && st == int'(T_MEM)), (op == OP_SW && st == int'(T_MEM)),
                 (st == int'(T_WBL)), e_pcsrc,
                 (op == OP_SLL),
                 (op == OP_ADDI || op == OP_ORI || op == OP_LW || op == OP_SW)};
        a_ctl = {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, WrRegDSrc, PCSrc, ALUSrcA, ALUSrcB};
        check($sformatf("rand%0d op%b k%0d state", n, op, k), 32'(state), 32'(st));
        check($sformatf("rand%0d op%b k%0d {pcw,irw,imrw,rgw,mrd,mwr,wds,pcsrc,srca,srcb}", n, op, k),
              32'(a_ctl), 32'(e_ctl));
        check($sformatf("rand%0d op%b extsel", n, op), 32'(ExtSel), 32'(op != OP_ORI));
        if (care) check($sformatf("rand%0d op%b aluop", n, op), 32'(ALUOp), 32'(alu_code));
        if (op == OP_JAL) check($sformatf("rand%0d regdst jal", n), 32'(RegDst), 32'd0);
        else if (is_rtype(op)) check($sformatf("rand%0d op%b regdst rd", n, op), 32'(RegDst), 32'd2);
        else if (is_itype(op)) check($sformatf("rand%0d op%b regdst rt", n, op), 32'(RegDst), 32'd1);
        @(posedge clk); #1;
      end
    end
    #1;
    check("final_state_if", 32'(state), 32'(T_IF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port opcode, input, 6 bits: instruction-register opcode field.
REQ-004 The block SHALL have port zero, input, 1 bit: ALU zero flag, valid in the EXE state.
REQ-005 The block SHALL have outputs PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, ALUSrcA, ALUSrcB, ExtSel and WrRegDSrc, each 1 bit.
REQ-006 The block SHALL have outputs PCSrc (2 bits), RegDst (2 bits) and ALUOp (3 bits).
REQ-007 The block SHALL have output state (3 bits): current FSM state, for debug only.

Function
REQ-008 The FSM states and encodings SHALL be: sIF=000, sID=001, sEXE_ALU=010, sEXE_BR=011, sEXE_LS=100, sMEM=101, sWB_ALU=110, sWB_LD=111.
REQ-009 From sIF, the FSM SHALL always go to sID.
REQ-010 From sID, j/jal/jr SHALL go to sIF; beq/bne SHALL go to sEXE_BR; sw/lw SHALL go to sEXE_LS; halt SHALL hold in sID; all others SHALL go to sEXE_ALU.
REQ-011 From sEXE_ALU, go to sWB_ALU; from sEXE_BR, go to sIF; from sEXE_LS, go to sMEM; from sMEM, sw SHALL go to sIF and lw to sWB_LD; from sWB_ALU and sWB_LD, go to sIF.
REQ-012 All outputs SHALL be combinational decodes of (state, opcode, zero); none SHALL be registered.
REQ-013 IRWre=1 and InsMemRW=1 SHALL occur only in sIF.
REQ-014 PCWre=1 SHALL occur exactly once per instruction, in its last cycle: sID for jumps, sEXE_BR, sMEM for sw, sWB_ALU, sWB_LD.
REQ-015 PCWre SHALL be 0 in sID for halt.
REQ-016 PCSrc SHALL be: 00 (PC+4) by default; 01 (branch) in sEXE_BR when (beq and zero) or (bne and !zero); 10 for jr; 11 for j/jal.
REQ-017 jal SHALL assert RegWre in sID with RegDst=00 ($31) and WrRegDSrc=0 (PC+4).
REQ-018 Otherwise RegDst SHALL be 01 (rt) for I-type and 10 (rd) for R-type.
REQ-019 mRD=1 SHALL occur only in sMEM for lw; mWR=1 only in sMEM for sw.
REQ-020 RegWre SHALL be 1 only in sWB_ALU, sWB_LD, and sID for jal.
REQ-021 WrRegDSrc SHALL be 1 (memory data) only in sWB_LD.
REQ-022 ALUOp SHALL be: add=000 (add/addi/lw/sw), sub=001 (sub/beq/bne), sll=010, or=011 (or/ori), and=100, slt=101.
REQ-023 ALUSrcA=1 SHALL apply for sll only; ALUSrcB=1 for addi/ori/lw/sw.
REQ-024 ExtSel SHALL be 0 (zero-extend) for ori and 1 (sign-extend) otherwise.
REQ-025 An undefined opcode SHALL be treated as a NOP through sEXE_ALU and sWB_ALU with RegWre=0; PC still advances.
REQ-026 Write enables SHALL never overlap across instructions: PCWre and IRWre are never 1 in the same cycle.

Reset
REQ-027 While reset=1 at a clk edge, the next state SHALL be sIF, regardless of current state (including mid-instruction or halt).
REQ-028 While reset=1, PCWre, IRWre, RegWre, mWR and mRD SHALL be forced to 0 combinationally.
REQ-029 The first sIF cycle after reset deasserts SHALL assert IRWre.
REQ-030 There SHALL be no initial-block state.

Structure
REQ-031 Package mcpu_pkg SHALL hold the opcode constants (add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111), the state encodings and the ALUOp codes.
REQ-032 Sub-module ctrl_decode SHALL hold the pure combinational opcode -> (ALUOp, ALUSrcA/B, ExtSel, RegDst) decode; the FSM and state-gated enables stay in the top module.

Verification
REQ-033 The bench SHALL cover: reset=1 for 2 cycles then opcode=add -> states IF,ID,EXE_ALU,WB_ALU,IF; PCWre high only in WB_ALU; RegWre=1 with RegDst=10.
REQ-034 The bench SHALL cover: lw -> IF,ID,EXE_LS,MEM,WB_LD (5 cycles); mRD in MEM; WrRegDSrc=1 and PCWre in WB_LD.
REQ-035 The bench SHALL cover: beq with zero=1 -> PCSrc=01 and PCWre=1 in EXE_BR; beq with zero=0 -> PCSrc=00; bne with zero=0 -> PCSrc=01.
REQ-036 The bench SHALL cover: jal -> 2-cycle instruction; in ID, PCSrc=11, PCWre=1, RegWre=1, RegDst=00.
REQ-037 The bench SHALL cover: halt -> FSM stays in ID with PCWre=0 for 20 cycles; then reset=1 for one edge -> state=IF.
REQ-038 The bench SHALL cover: reset asserted during MEM of sw -> mWR=0 in that cycle; next state IF.
